// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair (piso_tx, sipo).
package serdes_pkg;

  localparam int SERDES_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with a one-word holding buffer
// so consecutive words stream without an idle gap.
module piso_tx
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;

  assign in_ready     = !hold_full;
  assign accept       = in_valid && !hold_full;
  assign serial_valid = (state == SHIFT);
  assign serial_out   = (state == SHIFT) && sreg[WIDTH-1];
  assign done         = (state == SHIFT) && (cnt == CNT_LAST);
  assign busy         = (state == SHIFT) || hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != CNT_LAST) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
            if (accept) begin
              hold_data <= in_data;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // in_ready is low here, so no new word can collide with the drain
            sreg      <= hold_data;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            sreg <= in_data;
            cnt  <= '0;
          end else begin
            sreg  <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed and random stimulus for piso_tx with a bit-level scoreboard and a
// behavioural MSB-first receiver for loopback.
module tb_piso_tx;
  import serdes_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic b;
    logic last;
  } bit_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         done;
  logic         busy;

  bit_t         q[$];
  logic [W-1:0] words[$];
  logic [W-1:0] rx;
  int           checks;
  int           fails;

  piso_tx #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge: check the visible cycle, drive inputs, advance.
  task automatic step(input logic v, input logic [W-1:0] d);
    bit_t e;
    logic sv, so, dn, acc;
    logic [W-1:0] w;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("serial_valid", {31'd0, serial_valid}, {31'd0, q.size() > 0});
    chk("serial_out",   {31'd0, serial_out},   {31'd0, e.b});
    chk("done",         {31'd0, done},         {31'd0, e.last});
    chk("busy",         {31'd0, busy},         {31'd0, q.size() > 0});
    chk("in_ready",     {31'd0, in_ready},     {31'd0, q.size() <= W});
    sv = serial_valid;
    so = serial_out;
    dn = done;
    in_valid = v;
    in_data  = d;
    acc = v && (q.size() <= W);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      for (int i = W - 1; i >= 0; i--) q.push_back('{b: d[i], last: (i == 0)});
      words.push_back(d);
    end
    @(posedge clk);
    if (sv) rx = {rx[W-2:0], so};
    @(negedge clk);
    if (dn) begin
      if (words.size() > 0) begin
        w = words.pop_front();
        chk("loopback", {28'd0, rx}, {28'd0, w});
      end else begin
        checks++;
        fails++;
        $error("FAIL loopback_extra observed=done expected=no_word t=%0t", $time);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rx       = '0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    step(1'b0, '0);             // outputs held quiet while in reset
    rst = 1'b1;
    idle(2);

    // single word
    step(1'b1, 4'b1011);
    idle(5);

    // buffered back-to-back
    step(1'b1, 4'hA);
    step(1'b0, '0);
    step(1'b1, 4'h5);
    idle(9);

    // bypass at the done cycle
    step(1'b1, 4'hC);
    idle(3);
    step(1'b1, 4'h3);
    idle(5);

    // reset mid-frame with a buffered word
    step(1'b1, 4'hF);
    step(1'b1, 4'h9);
    step(1'b0, '0);
    #2 rst = 1'b0;
    #1;
    chk("rst_serial_valid", {31'd0, serial_valid}, 32'd0);
    chk("rst_serial_out",   {31'd0, serial_out},   32'd0);
    chk("rst_done",         {31'd0, done},         32'd0);
    chk("rst_busy",         {31'd0, busy},         32'd0);
    chk("rst_in_ready",     {31'd0, in_ready},     32'd1);
    q.delete();
    words.delete();
    rx = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    // random loopback
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 2) != 0), W'($urandom));
    end
    idle(12);
    chk("drain_bits",  q.size(),     32'd0);
    chk("drain_words", words.size(), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
